fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/return_stack.sv | 57 +++++
 rtl/fetch_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default widths,
// FSM state encoding and the return-stack pointer width.
package fetch_unit_pkg;

  // Defaults for the program counter width and the return-stack depth.
  localparam int PC_W        = 10;
  localparam int STACK_DEPTH = 4;

  // The stack pointer counts occupied entries, so it must be able to hold
  // the values 0..depth inclusive.
  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int SP_W = sp_width(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses. The pointer counts occupied entries; push on a
// full stack and pop on an empty stack are ignored here (the caller flags
// them). clear_i empties the stack in one cycle.
module return_stack
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH  = STACK_DEPTH,
  parameter int DATA_W = PC_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] top_o
);

  localparam int PTR_W = sp_width(DEPTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  sp_q;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  top_idx;

  assign full_o  = (sp_q == PTR_W'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign wr_idx  = IDX_W'(sp_q);
  assign top_idx = IDX_W'(sp_q - PTR_W'(1));
  assign top_o   = mem_q[top_idx];

  // Stack pointer: clear wins, then a guarded push or pop.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sp_q <= '0;
    end else if (clear_i) begin
      sp_q <= '0;
    end else if (push_i && !full_o) begin
      sp_q <= sp_q + PTR_W'(1);
    end else if (pop_i && !empty_o) begin
      sp_q <= sp_q - PTR_W'(1);
    end
  end

  // Entry storage, written at the current pointer on an accepted push.
  // NOTE: the storage array has no reset; an entry is only ever read after
  // a push has written it, so resetting it would add logic for no benefit.
  always_ff @(posedge Clk) begin
    if (push_i && !full_o && !clear_i) begin
      mem_q[wr_idx] <= data_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/RUN/DONE sequencer that steps the program
// counter, takes absolute/relative branches, and handles call/return via a
// small return stack. All outputs come straight from registers.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W        = fetch_unit_pkg::PC_W,
  parameter int STACK_DEPTH = fetch_unit_pkg::STACK_DEPTH
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [PC_W-1:0] StartAddr,
  input  logic            Halt,
  input  logic            Ret,
  input  logic            Call,
  input  logic            BranchAbs,
  input  logic            BranchRel,
  input  logic            Taken,
  input  logic [PC_W-1:0] absaddress,
  input  logic [7:0]      RelOffset,
  output logic [PC_W-1:0] ProgCtr,
  output logic            Running,
  output logic            Done,
  output logic            StackErr,
  output logic [15:0]     InstrCount
);

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            running_q;
  logic            done_q;
  logic            err_q;
  logic [15:0]     cnt_q;

  logic            in_run;
  logic            stk_clear;
  logic            stk_push;
  logic            stk_pop;
  logic            stk_full;
  logic            stk_empty;
  logic [PC_W-1:0] stk_top;
  logic [PC_W-1:0] pc_inc;
  logic            err_set;

  assign in_run    = (state_q == S_RUN);
  assign stk_clear = (state_q == S_IDLE) && Start;
  assign pc_inc    = pc_q + PC_W'(1);

  return_stack #(
    .DEPTH  (STACK_DEPTH),
    .DATA_W (PC_W)
  ) u_stack (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear_i (stk_clear),
    .push_i  (stk_push),
    .pop_i   (stk_pop),
    .data_i  (pc_inc),
    .full_o  (stk_full),
    .empty_o (stk_empty),
    .top_o   (stk_top)
  );

  // Pick this cycle's single RUN action by priority and derive the next PC.
  // NOTE: every signal gets a default before the if-chain so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_d     = pc_inc;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    err_set  = 1'b0;
    if (Halt) begin
      pc_d = pc_q;
    end else if (Ret) begin
      if (!stk_empty) begin
        stk_pop = in_run;
        pc_d    = stk_top;
      end else begin
        err_set = 1'b1;
      end
    end else if (Call) begin
      pc_d = absaddress;
      if (!stk_full) begin
        stk_push = in_run;
      end else begin
        err_set = 1'b1;
      end
    end else if (BranchAbs && Taken) begin
      pc_d = absaddress;
    end else if (BranchRel && Taken) begin
      // Sign-extend the 8-bit offset; the sum wraps modulo 2^PC_W.
      pc_d = pc_q + PC_W'($signed(RelOffset));
    end
  end

  // Sequencer with registered outputs; control inputs only act in RUN.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
            pc_q      <= StartAddr;
            cnt_q     <= '0;
            err_q     <= 1'b0;
          end
        end
        S_RUN: begin
          if (cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
          end
          pc_q <= pc_d;
          if (err_set) begin
            err_q <= 1'b1;
          end
          if (Halt) begin
            state_q   <= S_DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign ProgCtr    = pc_q;
  assign Running    = running_q;
  assign Done       = done_q;
  assign StackErr   = err_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the stimulus process steps a behavioural
// model and queues the expected post-edge outputs; a monitor compares them
// against the DUT on the falling edge.
module tb_fetch_unit;

  localparam int PC_W  = 10;
  localparam int MOD   = 1 << PC_W;
  localparam int DEPTH = 4;

  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;

  typedef struct {
    bit    start;
    int    start_addr;
    bit    halt;
    bit    ret;
    bit    call;
    bit    babs;
    bit    brel;
    bit    taken;
    int    abs_addr;
    int    rel;
  } stim_t;

  typedef struct {
    int    cyc;
    int    pc;
    bit    running;
    bit    done;
    bit    err;
    int    cnt;
    string tag;
  } exp_t;

  logic            Clk;
  logic            Reset;
  logic            Start;
  logic [PC_W-1:0] StartAddr;
  logic            Halt;
  logic            Ret;
  logic            Call;
  logic            BranchAbs;
  logic            BranchRel;
  logic            Taken;
  logic [PC_W-1:0] absaddress;
  logic [7:0]      RelOffset;
  logic [PC_W-1:0] ProgCtr;
  logic            Running;
  logic            Done;
  logic            StackErr;
  logic [15:0]     InstrCount;

  fetch_unit #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .StartAddr  (StartAddr),
    .Halt       (Halt),
    .Ret        (Ret),
    .Call       (Call),
    .BranchAbs  (BranchAbs),
    .BranchRel  (BranchRel),
    .Taken      (Taken),
    .absaddress (absaddress),
    .RelOffset  (RelOffset),
    .ProgCtr    (ProgCtr),
    .Running    (Running),
    .Done       (Done),
    .StackErr   (StackErr),
    .InstrCount (InstrCount)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_checks = 0;
  int n_err    = 0;
  int cyc_cnt  = 0;
  exp_t exp_q[$];

  always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

  // Reference model state.
  int m_phase;
  int m_pc;
  bit m_err;
  int m_cnt;
  int m_stack[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_pc    = 0;
    m_err   = 1'b0;
    m_cnt   = 0;
    m_stack.delete();
  endtask

  // One clock edge of the program-level behaviour.
  task automatic model_step(input stim_t s);
    case (m_phase)
      PH_IDLE: begin
        if (s.start) begin
          m_pc    = s.start_addr % MOD;
          m_cnt   = 0;
          m_err   = 1'b0;
          m_stack.delete();
          m_phase = PH_RUN;
        end
      end
      PH_RUN: begin
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        if (s.halt) begin
          m_phase = PH_DONE;
        end else if (s.ret) begin
          if (m_stack.size() > 0) begin
            m_pc = m_stack.pop_back();
          end else begin
            m_pc  = (m_pc + 1) % MOD;
            m_err = 1'b1;
          end
        end else if (s.call) begin
          if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + 1) % MOD);
          else m_err = 1'b1;
          m_pc = s.abs_addr % MOD;
        end else if (s.babs && s.taken) begin
          m_pc = s.abs_addr % MOD;
        end else if (s.brel && s.taken) begin
          m_pc = (m_pc + s.rel + MOD) % MOD;
        end else begin
          m_pc = (m_pc + 1) % MOD;
        end
      end
      default: m_phase = PH_IDLE;
    endcase
  endtask

  function automatic stim_t idle_s();
    stim_t s;
    s.start = 0; s.start_addr = 0; s.halt = 0; s.ret = 0; s.call = 0;
    s.babs = 0; s.brel = 0; s.taken = 0; s.abs_addr = 0; s.rel = 0;
    return s;
  endfunction

  // Drive one cycle of inputs, queue the expectation, advance past the edge.
  task automatic apply(input stim_t s, input string tag);
    exp_t e;
    Start      = s.start;
    StartAddr  = s.start_addr[PC_W-1:0];
    Halt       = s.halt;
    Ret        = s.ret;
    Call       = s.call;
    BranchAbs  = s.babs;
    BranchRel  = s.brel;
    Taken      = s.taken;
    absaddress = s.abs_addr[PC_W-1:0];
    RelOffset  = s.rel[7:0];
    model_step(s);
    e.cyc     = cyc_cnt + 1;
    e.pc      = m_pc;
    e.running = (m_phase == PH_RUN);
    e.done    = (m_phase == PH_DONE);
    e.err     = m_err;
    e.cnt     = m_cnt;
    e.tag     = tag;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  task automatic do_idle(input int n, input string tag);
    for (int i = 0; i < n; i++) apply(idle_s(), tag);
  endtask

  task automatic do_start(input int addr, input string tag);
    stim_t s = idle_s();
    s.start = 1; s.start_addr = addr;
    apply(s, tag);
  endtask

  task automatic do_branch(input bit babs, input bit brel, input bit taken,
                           input int abs_addr, input int rel, input string tag);
    stim_t s = idle_s();
    s.babs = babs; s.brel = brel; s.taken = taken; s.abs_addr = abs_addr; s.rel = rel;
    apply(s, tag);
  endtask

  task automatic do_call(input int abs_addr, input string tag);
    stim_t s = idle_s();
    s.call = 1; s.abs_addr = abs_addr;
    apply(s, tag);
  endtask

  task automatic do_ret(input string tag);
    stim_t s = idle_s();
    s.ret = 1;
    apply(s, tag);
  endtask

  // Asynchronous reset between clock edges, checked before any edge occurs.
  task automatic reset_pulse(input string tag);
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check({tag, ".pc"},      ProgCtr,    0);
    check({tag, ".running"}, Running,    0);
    check({tag, ".done"},    Done,       0);
    check({tag, ".err"},     StackErr,   0);
    check({tag, ".cnt"},     InstrCount, 0);
    model_reset();
    exp_q.delete();
    @(negedge Clk);
    #1;
    Reset = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  // Monitor: compare queued expectations on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc_cnt) begin
        e = exp_q.pop_front();
        check({e.tag, ".missed"}, 32'(cyc_cnt), 32'(e.cyc));
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
        e = exp_q.pop_front();
        check({e.tag, ".pc"},      ProgCtr,    e.pc);
        check({e.tag, ".running"}, Running,    e.running);
        check({e.tag, ".done"},    Done,       e.done);
        check({e.tag, ".err"},     StackErr,   e.err);
        check({e.tag, ".cnt"},     InstrCount, e.cnt);
      end
    end
  end

  initial begin
    stim_t s;
    Reset = 1'b1;
    s = idle_s();
    Start = 0; StartAddr = '0; Halt = 0; Ret = 0; Call = 0; BranchAbs = 0;
    BranchRel = 0; Taken = 0; absaddress = '0; RelOffset = '0;
    model_reset();
    #3;
    check("por.pc",  ProgCtr, 0);
    check("por.cnt", InstrCount, 0);
    @(negedge Clk);
    #1;
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Idle after reset; control inputs outside RUN are ignored.
    do_idle(1, "rst_idle");
    s = idle_s(); s.halt = 1; s.call = 1; s.babs = 1; s.taken = 1; s.abs_addr = 300;
    apply(s, "idle_ctrl");

    // Start at 14 then sequential steps; a second Start in RUN is ignored.
    do_start(14, "start14");
    do_idle(3, "seq14");
    do_start(500, "start_in_run");

    // Absolute branch taken / not taken from 20; relative not taken.
    do_branch(1, 0, 1, 20, 0, "goto20");
    do_branch(1, 0, 1, 44, 0, "abs_taken");
    do_branch(1, 0, 1, 20, 0, "goto20b");
    do_branch(1, 0, 0, 44, 0, "abs_not_taken");
    do_branch(0, 1, 0, 0, 50, "rel_not_taken");

    // Wrap at the top of the address space in both directions.
    do_branch(1, 0, 1, 1023, 0, "goto1023");
    do_idle(1, "wrap_up");
    do_branch(1, 0, 1, 2, 0, "goto2");
    do_branch(0, 1, 1, 0, -4, "rel_wrap_down");
    do_branch(0, 1, 1, 0, 5, "rel_wrap_up");

    // Each call lands one past the previous, so pushed returns are 11,65,66,67;
    // the fifth call overflows.
    do_branch(1, 0, 1, 10, 0, "goto10");
    do_call(64, "call1");
    do_call(65, "call2");
    do_call(66, "call3");
    do_call(67, "call4");
    do_call(63, "call5_ovf");
    for (int i = 0; i < 4; i++) do_ret($sformatf("ret%0d", i + 1));
    do_ret("ret5_underflow");

    // End the program, then 7 RUN cycles from 93 and a Halt at 100 with
    // Call and BranchAbs also asserted.
    s = idle_s(); s.halt = 1;
    apply(s, "halt_a");
    do_idle(2, "after_halt_a");
    do_start(93, "start93");
    do_idle(7, "run93");
    s = idle_s(); s.halt = 1; s.call = 1; s.babs = 1; s.taken = 1; s.abs_addr = 500;
    apply(s, "halt100");
    do_start(7, "start_in_done");
    do_idle(2, "post_done");

    // Reset mid-program at 75, then a fresh program with an empty stack.
    do_start(70, "start70");
    do_idle(5, "run70");
    reset_pulse("mid_reset");
    do_idle(2, "post_reset");
    do_start(200, "start200");
    do_ret("ret_after_reset");
    do_idle(2, "run200");

    // Randomized programs.
    for (int i = 0; i < 400; i++) begin
      s = idle_s();
      if (m_phase == PH_IDLE) begin
        s.start      = ($urandom_range(0, 1) == 1);
        s.start_addr = $urandom_range(0, MOD - 1);
      end
      s.halt     = ($urandom_range(0, 19) == 0);
      s.ret      = ($urandom_range(0, 5) == 0);
      s.call     = ($urandom_range(0, 5) == 0);
      s.babs     = ($urandom_range(0, 4) == 0);
      s.brel     = ($urandom_range(0, 4) == 0);
      s.taken    = ($urandom_range(0, 1) == 1);
      s.abs_addr = $urandom_range(0, MOD - 1);
      s.rel      = int'($urandom_range(0, 255)) - 128;
      apply(s, "rand");
    end

    // Let the monitor consume the last expectations, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clk);
    #1;
    check("drain", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
